// File: rtl/mux_32x8_pkg.sv
// Shared widths, FSM encoding and byte-extraction helper for the 32->8 serializer.
package mux_32x8_pkg;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned FIFO_DEPTH     = 2;
    localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int unsigned SEL_W          = 2;
    localparam int unsigned CNT_W          = 2;
    localparam int unsigned PTR_W          = 1;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(BYTES_PER_WORD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Byte idx of a word, MSB first (idx 0 -> bits [31:24]).
    function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                     input logic [SEL_W-1:0]  idx);
        logic [WORD_W-1:0] sh;
        sh = w << (BYTE_W * idx);
        return sh[WORD_W-1 -: BYTE_W];
    endfunction

endpackage

// File: rtl/mux_32x8_if.sv
// Upstream word handshake plus downstream byte stream of mux_32x8.
//   data_in_32/valid_in_32 : word offered by upstream
//   ready_out_32           : block can accept a word this cycle
//   data_out_8/valid_out_8 : serialized byte stream
//   selector_out           : index (0..3) of the byte on data_out_8
interface mux_32x8_if;
    import mux_32x8_pkg::*;

    logic [WORD_W-1:0] data_in_32;
    logic              valid_in_32;
    logic              ready_out_32;
    logic [BYTE_W-1:0] data_out_8;
    logic              valid_out_8;
    logic [SEL_W-1:0]  selector_out;

    modport master (
        output data_in_32, valid_in_32,
        input  ready_out_32, data_out_8, valid_out_8, selector_out
    );

    modport slave (
        input  data_in_32, valid_in_32,
        output ready_out_32, data_out_8, valid_out_8, selector_out
    );

endinterface

// File: rtl/fifo_2x32.sv
// Two-entry word FIFO feeding the serializer.
//   clk_4f, reset_L : clock, async active-low reset
//   push/push_data  : write a word (ignored when full)
//   pop             : drop the head word (ignored when empty)
//   pop_data        : current head word
//   count           : occupancy 0..2
module fifo_2x32
    import mux_32x8_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count
);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok  = push && (count_q < CNT_W'(FIFO_DEPTH));
    assign pop_ok   = pop && (count_q != '0);
    assign pop_data = mem[rd_ptr];
    assign count    = count_q;

    // Storage, 1-bit pointers wrap naturally modulo 2.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mux_32x8.sv
// 32-bit word to 8-bit byte serializer with a 2-word input FIFO.
//   clk_4f  : byte-rate clock
//   reset_L : async active-low reset
//   bus     : slave side of mux_32x8_if (word in, byte stream out)
module mux_32x8
    import mux_32x8_pkg::*;
(
    input  logic       clk_4f,
    input  logic       reset_L,
    mux_32x8_if.slave  bus
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              ready_c;
    logic              push;
    logic              pop;
    logic [WORD_W-1:0] head;
    logic [CNT_W-1:0]  count;

    assign ready_c = (count < CNT_W'(FIFO_DEPTH)) && reset_L;
    assign push    = bus.valid_in_32 && ready_c;

    fifo_2x32 u_fifo (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .push      (push),
        .push_data (bus.data_in_32),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    // State and output registers.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    // Next state: after the last byte, load the next word directly so words stream gap-free.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    data_d  = word_byte(head, '0);
                    sel_d   = '0;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (sel_q != LAST_SEL) begin
                    sel_d  = sel_q + SEL_W'(1);
                    data_d = word_byte(hold_q, sel_q + SEL_W'(1));
                end else if (count != '0) begin
                    pop     = 1'b1;
                    hold_d  = head;
                    data_d  = word_byte(head, '0);
                    sel_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    data_d  = '0;
                    sel_d   = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_out_32 = ready_c;
    assign bus.data_out_8   = data_q;
    assign bus.valid_out_8  = valid_q;
    assign bus.selector_out = sel_q;

endmodule

// File: doc/mux_32x8.md
MUX_32X8 -- requirements
Module: mux_32x8

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be asynchronous and active-low, with ports clk_4f and reset_L.
REQ-002 Port clk_4f: input, 1 bit, byte-rate clock; all state updates on its rising edge.
REQ-003 Port reset_L: input, 1 bit, asynchronous active-low reset.
REQ-004 Port data_in_32: input, 32 bits, parallel word from upstream.
REQ-005 Port valid_in_32: input, 1 bit, data_in_32 holds a word to accept.
REQ-006 Port ready_out_32: output, 1 bit, block can accept a word this cycle.
REQ-007 Port data_out_8: output, 8 bits, serialized byte for the downstream 8x32 stage.
REQ-008 Port valid_out_8: output, 1 bit, data_out_8 holds a valid byte.
REQ-009 Port selector_out: output, 2 bits, index (0..3) of the byte on data_out_8, driven to the downstream selector_clk_4f.

Function
REQ-010 A word SHALL be accepted at a rising edge where valid_in_32=1 and ready_out_32=1.
REQ-011 Accepted words SHALL enter a 2-entry FIFO; ready_out_32 SHALL equal (fifo_count<2) AND reset_L.
REQ-012 valid_in_32 while ready_out_32=0 SHALL be ignored: no state change and no word loss, because upstream holds the word.
REQ-013 The FSM SHALL have two states: IDLE and SEND.
REQ-014 In IDLE with fifo_count>0, the next edge SHALL pop the head word into a 32-bit hold register and drive data_out_8=word[31:24], selector_out=0, valid_out_8=1, and move to SEND.
REQ-015 In SEND with selector_out=k<3, the next edge SHALL drive selector_out=k+1 and data_out_8=hold[31-8(k+1) -: 8].
REQ-016 In SEND with selector_out=3 and fifo_count>0, the next edge SHALL pop the next word and drive its byte 0 with selector_out=0, so no bubble occurs between words.
REQ-017 In SEND with selector_out=3 and fifo_count=0, the next edge SHALL drive valid_out_8=0, data_out_8=0, selector_out=0, and go to IDLE.
REQ-018 Byte order SHALL be MSB first: bits[31:24], [23:16], [15:8], [7:0].
REQ-019 Latency SHALL be one edge: a word accepted into an empty FIFO at edge N while IDLE SHALL produce byte 0 after edge N+1.
REQ-020 Simultaneous push and pop on the same edge SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-021 FIFO pointers SHALL be 1 bit and wrap modulo 2; fifo_count SHALL be 2 bits and never exceed 2.
REQ-022 Sustained throughput SHALL be one word per 4 clk_4f cycles; with continuous valid_in_32, ready_out_32 SHALL drop once the FIFO fills.
REQ-023 When valid_out_8=0, data_out_8 and selector_out SHALL be 0.

Reset
REQ-024 While reset_L=0, the block SHALL force data_out_8=0, valid_out_8=0, selector_out=0, ready_out_32=0, fifo_count=0, pointers=0, hold=0, and state=IDLE, asynchronously.
REQ-025 Reset asserted mid-word SHALL discard the partial word and all FIFO contents.
REQ-026 After reset deasserts, ready_out_32 SHALL be 1, and the first acceptance SHALL be possible at the next edge.

Structure
REQ-027 A shared defines file SHALL hold WORD_W=32, BYTE_W=8, FIFO_DEPTH=2, and the state encodings IDLE=0 and SEND=1.
REQ-028 The FIFO SHALL be a sub-module named fifo_2x32, with push/pop/data/count ports; the FSM and serializer SHALL reside in mux_32x8.

Verification
REQ-029 Single word: reset 3 time units, then push 0x01020304 once -> bytes 01,02,03,04 on consecutive edges with selector_out 0,1,2,3; valid_out_8 then drops to 0.
REQ-030 Back-to-back: push 0xAABBCCDD then 0x11223344 -> eight consecutive valid bytes AA,BB,CC,DD,11,22,33,44 with no gap.
REQ-031 Backpressure: hold valid_in_32=1 with incrementing words 1,2,3,4,5 -> ready_out_32 low while FIFO full; output order 1..5 with no loss or duplication.
REQ-032 Reset mid-word: assert reset_L=0 after byte 1 of 0xDEADBEEF -> outputs 0 immediately; after release, a push of 0x0000000F outputs 00,00,00,0F only.
REQ-033 Push/pop collision: push a word on the same edge that byte 3 of the previous word completes with fifo_count=1 -> count stays 1 and order is preserved.
REQ-034 Loopback: mux_32x8 output drives the 8x32 converter -> data_out_8x32 equals each pushed word, compared against both behavioral and structural versions.
